// File: rtl/clock_mode_controller.sv
// Button-driven mode/settings sequencer for digital_clock: time edit, alarm edit and stopwatch
// control, with staged edits committed on confirmation and abandoned after an idle timeout.
module clock_mode_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 30,
  parameter int unsigned ALARM_RST_HOUR = 12
) (
  input  logic       Clk_1sec,
  input  logic       reset_in,
  input  logic       mode_btn_in,
  input  logic       next_btn_in,
  input  logic       up_btn_in,
  input  logic [3:0] hours_in,
  input  logic [5:0] minutes_in,
  input  logic       am_pm_in,
  output logic       set_time_out,
  output logic [3:0] set_hour_out,
  output logic [5:0] set_minute_out,
  output logic       set_ampm_out,
  output logic [3:0] alarm_hour_out,
  output logic [5:0] alarm_minute_out,
  output logic       alarm_ampm_out,
  output logic       stopwatch_on_out,
  output logic       stopwatch_reset_out,
  output logic [3:0] edit_hour_out,
  output logic [5:0] edit_minute_out,
  output logic       edit_ampm_out,
  output logic [2:0] mode_out
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] AlarmRstHour = 4'(ALARM_RST_HOUR);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StTHour = 3'd1,
    StTMin  = 3'd2,
    StTAmpm = 3'd3,
    StAHour = 3'd4,
    StAMin  = 3'd5,
    StAAmpm = 3'd6,
    StSw    = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            set_time_q, set_time_d;
  logic [3:0]      set_hour_q, set_hour_d;
  logic [5:0]      set_minute_q, set_minute_d;
  logic            set_ampm_q, set_ampm_d;
  logic [3:0]      alarm_hour_q, alarm_hour_d;
  logic [5:0]      alarm_minute_q, alarm_minute_d;
  logic            alarm_ampm_q, alarm_ampm_d;
  logic            sw_on_q, sw_on_d;
  logic            sw_rst_q, sw_rst_d;
  logic [3:0]      edit_hour_q, edit_hour_d;
  logic [5:0]      edit_minute_q, edit_minute_d;
  logic            edit_ampm_q, edit_ampm_d;

  logic is_time_grp, is_hour_fld, is_min_fld;

  // Out-of-range hours (0, 13..15) also restart at 1.
  function automatic logic [3:0] next_hour(input logic [3:0] h);
    return (h >= 4'd12 || h == 4'd0) ? 4'd1 : h + 4'd1;
  endfunction

  function automatic logic [5:0] next_minute(input logic [5:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  assign is_time_grp = (state_q == StTHour) || (state_q == StTMin) || (state_q == StTAmpm);
  assign is_hour_fld = (state_q == StTHour) || (state_q == StAHour);
  assign is_min_fld  = (state_q == StTMin) || (state_q == StAMin);

  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    set_time_d     = 1'b0;
    sw_rst_d       = 1'b0;
    set_hour_d     = set_hour_q;
    set_minute_d   = set_minute_q;
    set_ampm_d     = set_ampm_q;
    alarm_hour_d   = alarm_hour_q;
    alarm_minute_d = alarm_minute_q;
    alarm_ampm_d   = alarm_ampm_q;
    sw_on_d        = sw_on_q;
    edit_hour_d    = edit_hour_q;
    edit_minute_d  = edit_minute_q;
    edit_ampm_d    = edit_ampm_q;

    unique case (state_q)
      StIdle: begin
        if (mode_btn_in) begin
          state_d       = StTHour;
          edit_hour_d   = hours_in;
          edit_minute_d = minutes_in;
          edit_ampm_d   = am_pm_in;
        end
      end
      StSw: begin
        if (mode_btn_in) begin
          state_d = StIdle;
        end else if (next_btn_in) begin
          sw_rst_d = 1'b1;
        end else if (up_btn_in) begin
          sw_on_d = ~sw_on_q;
        end
      end
      default: begin
        // Edit states: the counter only advances on cycles with no button activity.
        if (mode_btn_in) begin
          if (is_time_grp) begin
            state_d       = StAHour;
            edit_hour_d   = alarm_hour_q;
            edit_minute_d = alarm_minute_q;
            edit_ampm_d   = alarm_ampm_q;
          end else begin
            state_d = StSw;
          end
        end else if (next_btn_in) begin
          case (state_q)
            StTHour: state_d = StTMin;
            StTMin:  state_d = StTAmpm;
            StAHour: state_d = StAMin;
            StAMin:  state_d = StAAmpm;
            StTAmpm: begin
              state_d      = StIdle;
              set_time_d   = 1'b1;
              set_hour_d   = edit_hour_q;
              set_minute_d = edit_minute_q;
              set_ampm_d   = edit_ampm_q;
            end
            StAAmpm: begin
              state_d        = StIdle;
              alarm_hour_d   = edit_hour_q;
              alarm_minute_d = edit_minute_q;
              alarm_ampm_d   = edit_ampm_q;
            end
            default: state_d = StIdle;
          endcase
        end else if (up_btn_in) begin
          if (is_hour_fld) begin
            edit_hour_d = next_hour(edit_hour_q);
          end else if (is_min_fld) begin
            edit_minute_d = next_minute(edit_minute_q);
          end else begin
            edit_ampm_d = ~edit_ampm_q;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk_1sec or negedge reset_in) begin
    if (!reset_in) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      set_time_q     <= 1'b0;
      set_hour_q     <= 4'd12;
      set_minute_q   <= 6'd0;
      set_ampm_q     <= 1'b0;
      alarm_hour_q   <= AlarmRstHour;
      alarm_minute_q <= 6'd0;
      alarm_ampm_q   <= 1'b0;
      sw_on_q        <= 1'b0;
      sw_rst_q       <= 1'b0;
      edit_hour_q    <= 4'd12;
      edit_minute_q  <= 6'd0;
      edit_ampm_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      set_time_q     <= set_time_d;
      set_hour_q     <= set_hour_d;
      set_minute_q   <= set_minute_d;
      set_ampm_q     <= set_ampm_d;
      alarm_hour_q   <= alarm_hour_d;
      alarm_minute_q <= alarm_minute_d;
      alarm_ampm_q   <= alarm_ampm_d;
      sw_on_q        <= sw_on_d;
      sw_rst_q       <= sw_rst_d;
      edit_hour_q    <= edit_hour_d;
      edit_minute_q  <= edit_minute_d;
      edit_ampm_q    <= edit_ampm_d;
    end
  end

  assign set_time_out        = set_time_q;
  assign set_hour_out        = set_hour_q;
  assign set_minute_out      = set_minute_q;
  assign set_ampm_out        = set_ampm_q;
  assign alarm_hour_out      = alarm_hour_q;
  assign alarm_minute_out    = alarm_minute_q;
  assign alarm_ampm_out      = alarm_ampm_q;
  assign stopwatch_on_out    = sw_on_q;
  assign stopwatch_reset_out = sw_rst_q;
  assign edit_hour_out       = edit_hour_q;
  assign edit_minute_out     = edit_minute_q;
  assign edit_ampm_out       = edit_ampm_q;
  assign mode_out            = state_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Bench for clock_mode_controller: directed vector table, hand-written corner sequences and
// random button traffic checked against a group/field reference model.
module tb_clock_mode_controller;

  localparam int Timeout = 30;
  localparam int AlarmRst = 12;

  logic       clk = 1'b0;
  logic       reset_in = 1'b0;
  logic       mode_btn = 1'b0, next_btn = 1'b0, up_btn = 1'b0;
  logic [3:0] hours_in = 4'd12;
  logic [5:0] minutes_in = 6'd0;
  logic       am_pm_in = 1'b0;
  logic       set_time_out, set_ampm_out, alarm_ampm_out, sw_on, sw_rst, edit_ampm_out;
  logic [3:0] set_hour_out, alarm_hour_out, edit_hour_out;
  logic [5:0] set_minute_out, alarm_minute_out, edit_minute_out;
  logic [2:0] mode_out;

  int n_pass = 0;
  int n_total = 0;

  clock_mode_controller #(
    .TIMEOUT_CYCLES(Timeout),
    .ALARM_RST_HOUR(AlarmRst)
  ) dut (
    .Clk_1sec(clk),
    .reset_in(reset_in),
    .mode_btn_in(mode_btn),
    .next_btn_in(next_btn),
    .up_btn_in(up_btn),
    .hours_in(hours_in),
    .minutes_in(minutes_in),
    .am_pm_in(am_pm_in),
    .set_time_out(set_time_out),
    .set_hour_out(set_hour_out),
    .set_minute_out(set_minute_out),
    .set_ampm_out(set_ampm_out),
    .alarm_hour_out(alarm_hour_out),
    .alarm_minute_out(alarm_minute_out),
    .alarm_ampm_out(alarm_ampm_out),
    .stopwatch_on_out(sw_on),
    .stopwatch_reset_out(sw_rst),
    .edit_hour_out(edit_hour_out),
    .edit_minute_out(edit_minute_out),
    .edit_ampm_out(edit_ampm_out),
    .mode_out(mode_out)
  );

  always #5 clk = ~clk;

  // Reference model: group 0 idle, 1 time, 2 alarm, 3 stopwatch; field 0 hour, 1 min, 2 ampm.
  int         m_group, m_field, m_idle;
  logic [3:0] m_sh, m_ah, m_eh;
  logic [5:0] m_sm, m_am, m_em;
  logic       m_sa, m_aa, m_ea, m_on, m_strobe, m_swr;

  function automatic logic [2:0] m_code();
    if (m_group == 0) return 3'd0;
    if (m_group == 3) return 3'd7;
    return 3'(3 * (m_group - 1) + m_field + 1);
  endfunction

  task automatic m_reset();
    m_group = 0; m_field = 0; m_idle = 0;
    m_sh = 4'd12; m_sm = 6'd0; m_sa = 1'b0;
    m_ah = 4'(AlarmRst); m_am = 6'd0; m_aa = 1'b0;
    m_eh = 4'd12; m_em = 6'd0; m_ea = 1'b0;
    m_on = 1'b0; m_strobe = 1'b0; m_swr = 1'b0;
  endtask

  task automatic m_step(input bit mb, input bit nb, input bit ub);
    int code_before;
    code_before = int'(m_code());
    m_strobe = 1'b0;
    m_swr = 1'b0;
    if (mb) begin
      case (m_group)
        0: begin m_group = 1; m_field = 0; m_eh = hours_in; m_em = minutes_in; m_ea = am_pm_in; end
        1: begin m_group = 2; m_field = 0; m_eh = m_ah; m_em = m_am; m_ea = m_aa; end
        2: m_group = 3;
        default: m_group = 0;
      endcase
    end else if (nb) begin
      if (m_group == 3) m_swr = 1'b1;
      else if (m_group != 0 && m_field < 2) m_field++;
      else if (m_group == 1) begin
        m_sh = m_eh; m_sm = m_em; m_sa = m_ea; m_strobe = 1'b1; m_group = 0;
      end else if (m_group == 2) begin
        m_ah = m_eh; m_am = m_em; m_aa = m_ea; m_group = 0;
      end
    end else if (ub) begin
      if (m_group == 3) m_on = ~m_on;
      else if (m_group != 0) begin
        if (m_field == 0) m_eh = (m_eh >= 4'd12) ? 4'd1 : m_eh + 4'd1;
        else if (m_field == 1) m_em = (m_em >= 6'd59) ? 6'd0 : m_em + 6'd1;
        else m_ea = ~m_ea;
      end
    end
    if (mb || nb || ub || int'(m_code()) != code_before) m_idle = 0;
    else if (m_group == 1 || m_group == 2) begin
      m_idle++;
      if (m_idle == Timeout) begin m_group = 0; m_idle = 0; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp_model();
    chk("mode", 32'(mode_out), 32'(m_code()));
    chk("set_strobe", 32'(set_time_out), 32'(m_strobe));
    chk("set_val", 32'({set_hour_out, set_minute_out, set_ampm_out}), 32'({m_sh, m_sm, m_sa}));
    chk("alarm_val", 32'({alarm_hour_out, alarm_minute_out, alarm_ampm_out}),
        32'({m_ah, m_am, m_aa}));
    chk("edit_val", 32'({edit_hour_out, edit_minute_out, edit_ampm_out}), 32'({m_eh, m_em, m_ea}));
    chk("sw_on", 32'(sw_on), 32'(m_on));
    chk("sw_reset", 32'(sw_rst), 32'(m_swr));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"}, 32'(mode_out), 32'd0);
    chk({tag, "_strobes"}, 32'({set_time_out, sw_rst, sw_on}), 32'd0);
    chk({tag, "_set"}, 32'({set_hour_out, set_minute_out, set_ampm_out}), 32'({4'd12, 7'd0}));
    chk({tag, "_alarm"}, 32'({alarm_hour_out, alarm_minute_out, alarm_ampm_out}),
        32'({4'd12, 7'd0}));
    chk({tag, "_edit"}, 32'({edit_hour_out, edit_minute_out, edit_ampm_out}), 32'({4'd12, 7'd0}));
  endtask

  task automatic step(input bit mb, input bit nb, input bit ub);
    @(negedge clk);
    mode_btn = mb; next_btn = nb; up_btn = ub;
    @(posedge clk);
    m_step(mb, nb, ub);
    #1;
    cmp_model();
    mode_btn = 1'b0; next_btn = 1'b0; up_btn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit         mb, nb, ub;
    logic [2:0] mode;
    logic       strobe;
    logic [3:0] eh;
    logic [5:0] em;
    logic       ea;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int r;
    bit mb, nb, ub;

    tbl[0] = '{1, 0, 0, 3'd1, 1'b0, 4'd3, 6'd58, 1'b1};
    tbl[1] = '{0, 0, 1, 3'd1, 1'b0, 4'd4, 6'd58, 1'b1};
    tbl[2] = '{0, 1, 0, 3'd2, 1'b0, 4'd4, 6'd58, 1'b1};
    tbl[3] = '{0, 0, 1, 3'd2, 1'b0, 4'd4, 6'd59, 1'b1};
    tbl[4] = '{0, 0, 1, 3'd2, 1'b0, 4'd4, 6'd0, 1'b1};
    tbl[5] = '{0, 0, 1, 3'd2, 1'b0, 4'd4, 6'd1, 1'b1};
    tbl[6] = '{0, 1, 0, 3'd3, 1'b0, 4'd4, 6'd1, 1'b1};
    tbl[7] = '{0, 0, 1, 3'd3, 1'b0, 4'd4, 6'd1, 1'b0};
    tbl[8] = '{0, 1, 0, 3'd0, 1'b1, 4'd4, 6'd1, 1'b0};
    tbl[9] = '{0, 0, 0, 3'd0, 1'b0, 4'd4, 6'd1, 1'b0};

    m_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("in_reset");
    @(negedge clk) reset_in = 1'b1;
    idle(1);
    chk_reset_vals("after_reset");

    // Time set from table.
    hours_in = 4'd3; minutes_in = 6'd58; am_pm_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].mb, tbl[i].nb, tbl[i].ub);
      chk($sformatf("tbl%0d_mode", i), 32'(mode_out), 32'(tbl[i].mode));
      chk($sformatf("tbl%0d_strobe", i), 32'(set_time_out), 32'(tbl[i].strobe));
      chk($sformatf("tbl%0d_edit", i), 32'({edit_hour_out, edit_minute_out, edit_ampm_out}),
          32'({tbl[i].eh, tbl[i].em, tbl[i].ea}));
    end
    chk("time_committed", 32'({set_hour_out, set_minute_out, set_ampm_out}), 32'({4'd4, 6'd1, 1'b0}));

    // Wraps, then leave through alarm and stopwatch.
    hours_in = 4'd12; minutes_in = 6'd59; am_pm_in = 1'b0;
    step(1, 0, 0);
    step(0, 0, 1);
    chk("hour_wrap", 32'(edit_hour_out), 32'd1);
    step(0, 1, 0);
    step(0, 0, 1);
    chk("minute_wrap", 32'(edit_minute_out), 32'd0);
    step(1, 0, 0);
    chk("discard_no_strobe", 32'({mode_out, set_time_out}), 32'({3'd4, 1'b0}));
    step(1, 0, 0);
    step(1, 0, 0);

    // Alarm path with a discarded time edit.
    step(1, 0, 0);
    step(0, 0, 1);
    step(1, 0, 0);
    chk("alarm_entry", 32'({mode_out, set_time_out}), 32'({3'd4, 1'b0}));
    chk("time_kept", 32'({set_hour_out, set_minute_out, set_ampm_out}), 32'({4'd4, 6'd1, 1'b0}));
    for (int i = 0; i < 6; i++) step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    chk("alarm_commit", 32'({mode_out, alarm_hour_out, alarm_minute_out, alarm_ampm_out}),
        32'({3'd0, 4'd6, 6'd0, 1'b1}));

    // Stopwatch.
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    chk("sw_mode", 32'(mode_out), 32'd7);
    step(0, 0, 1);
    chk("sw_on", 32'(sw_on), 32'd1);
    step(0, 1, 0);
    chk("sw_reset_pulse", 32'({sw_rst, sw_on}), 32'({1'b1, 1'b1}));
    step(0, 0, 0);
    chk("sw_reset_end", 32'(sw_rst), 32'd0);
    step(1, 0, 0);
    chk("sw_exit", 32'({mode_out, sw_on}), 32'({3'd0, 1'b1}));

    // Timeout, and a pulse on the terminal cycle.
    hours_in = 4'd7; minutes_in = 6'd20; am_pm_in = 1'b1;
    step(1, 0, 0); step(0, 1, 0);
    idle(Timeout - 1);
    chk("timeout_not_yet", 32'(mode_out), 32'd2);
    idle(1);
    chk("timeout_idle", 32'({mode_out, set_time_out}), 32'd0);
    chk("timeout_set_kept", 32'({set_hour_out, set_minute_out, set_ampm_out}),
        32'({4'd4, 6'd1, 1'b0}));
    step(1, 0, 0); step(0, 1, 0);
    idle(Timeout - 1);
    step(0, 0, 1);
    chk("terminal_pulse_wins", 32'({mode_out, edit_minute_out}), 32'({3'd2, 6'd21}));
    idle(Timeout);
    chk("timeout_after_pulse", 32'(mode_out), 32'd0);

    // Priority: mode beats next and up.
    step(1, 0, 0);
    step(1, 1, 1);
    chk("priority", 32'({mode_out, edit_hour_out, edit_minute_out, edit_ampm_out}),
        32'({3'd4, 4'd6, 6'd0, 1'b1}));
    step(1, 0, 0); step(1, 0, 0);

    // Asynchronous reset mid-edit.
    step(1, 0, 0); step(0, 0, 1);
    #2 reset_in = 1'b0;
    #1 chk_reset_vals("async_reset");
    m_reset();
    @(negedge clk) reset_in = 1'b1;
    idle(1);

    // Random traffic, including out-of-range hours and coincident pulses.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      hours_in = 4'($urandom_range(0, 15));
      minutes_in = 6'($urandom_range(0, 63));
      am_pm_in = 1'($urandom);
      mb = (r < 12) || (r >= 97);
      nb = (r >= 12 && r < 30) || (r >= 94);
      ub = (r >= 30 && r < 60) || (r >= 92);
      step(mb, nb, ub);
      if (i % 120 == 60) idle(Timeout + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clock_mode_controller.md
Name: clock_mode_controller

Overview:
Button-driven mode/settings sequencer that sits in front of digital_clock and drives its set-time, alarm and stopwatch control inputs. Three synchronous push-button pulses walk an 8-state FSM through time edit, alarm edit and stopwatch control. Edits are staged in a local buffer and committed only on confirmation; an inactivity timeout abandons them. Alarm settings are held here, and the current time is read back from digital_clock to preload time edits.

Parameters:
TIMEOUT_CYCLES, 30, idle cycles in an edit state before abandoning the edit (30 s at 1 Hz)
ALARM_RST_HOUR, 12, alarm_hour_out reset value (1..12)

Ports:
Clk_1sec  input  1  clock, all logic on rising edge
reset_in  input  1  asynchronous active-low reset
mode_btn_in  input  1  one-cycle pulse, advance mode group
next_btn_in  input  1  one-cycle pulse, next field / confirm
up_btn_in  input  1  one-cycle pulse, increment field / toggle
hours_in  input  4  current clock hours (1..12) from digital_clock
minutes_in  input  6  current clock minutes (0..59)
am_pm_in  input  1  current clock am/pm (0 = am)
set_time_out  output  1  one-cycle commit strobe to digital_clock
set_hour_out  output  4  committed hour
set_minute_out  output  6  committed minute
set_ampm_out  output  1  committed am/pm
alarm_hour_out  output  4  alarm hour
alarm_minute_out  output  6  alarm minute
alarm_ampm_out  output  1  alarm am/pm
stopwatch_on_out  output  1  stopwatch run level
stopwatch_reset_out  output  1  one-cycle stopwatch clear pulse
edit_hour_out  output  4  edit buffer hour, for display
edit_minute_out  output  6  edit buffer minute
edit_ampm_out  output  1  edit buffer am/pm
mode_out  output  3  current state code

Behaviour:
- All outputs are registered. Inputs are sampled at the rising edge, and the response is visible after that same edge.
- Reset (reset_in = 0, asynchronous):
  - state IDLE; set_time_out and stopwatch_reset_out 0; stopwatch_on_out 0.
  - set_* = 12:00, ampm 0.
  - alarm = ALARM_RST_HOUR:00, ampm 0.
  - edit buffer 12:00, ampm 0; timeout counter 0.
- State codes: IDLE 0, T_HOUR 1, T_MIN 2, T_AMPM 3, A_HOUR 4, A_MIN 5, A_AMPM 6, SW 7. mode_out equals the state code.
- Button priority when pulses coincide: mode > next > up. Only the highest-priority pulse acts.
- IDLE:
  - mode -> T_HOUR; edit buffer loads hours_in/minutes_in/am_pm_in.
  - next and up are ignored.
- T_* and A_* field editing:
  - up in *_HOUR: increment hour 1..12, with 12 wrapping to 1.
  - up in *_MIN: increment minute, with 59 wrapping to 0.
  - up in *_AMPM: toggle ampm.
  - next advances HOUR -> MIN -> AMPM within the group.
- Time commit: next in T_AMPM -> IDLE. Same edge: set_* <= edit buffer and set_time_out = 1 for exactly one cycle.
- Alarm commit: next in A_AMPM -> IDLE. Same edge: alarm_* <= edit buffer. No strobe.
- Leaving T_*: mode in any T_* -> A_HOUR. Time edits are discarded; edit buffer loads the alarm_* registers.
- Leaving A_*: mode in any A_* -> SW. Alarm edits are discarded; alarm_* are unchanged.
- SW:
  - up toggles stopwatch_on_out.
  - next drives stopwatch_reset_out = 1 for one cycle; stopwatch_on_out is unchanged.
  - mode -> IDLE; stopwatch_on_out keeps its value.
- Timeout counter:
  - Counts only in T_* and A_* states.
  - Clears on any button pulse and on every state change.
  - When it reaches TIMEOUT_CYCLES with no pulse: state -> IDLE. Edits are discarded and no commit or strobe occurs.
  - A pulse arriving on the terminal cycle wins over the timeout.
- Out-of-range values: hours_in values outside 1..12 are loaded unchecked. The next up sets the hour to 1 if it is >= 12 or 0; otherwise hour + 1. Minutes >= 59 wrap to 0 on up.
- Reset mid-edit returns to IDLE immediately. Any pending strobe or pulse is forced to 0.

Test Plan:
- Reset: release reset_in -> mode_out 0, set_* 12:00 am, alarm 12:00 am, both strobes 0, stopwatch_on_out 0.
- Time set: hours_in 3, minutes_in 58, am_pm_in 1; mode, up, next, up×3, next, up, next -> edit 4:01 am. Then set_time_out is high for exactly one cycle with set_hour_out 4, set_minute_out 1, set_ampm_out 0; mode_out returns to 0.
- Wrap: edit hour 12 + up -> 1; minute 59 + up -> 0.
- Alarm path with discard: mode, up (time edit), mode -> A_HOUR, and set_time_out never pulses. Then up×6, next, next, up, next -> alarm_*_out 6:00 pm.
- Stopwatch: reach SW; up -> stopwatch_on_out 1; next -> stopwatch_reset_out a 1-cycle pulse, on stays 1; mode -> IDLE with on still 1.
- Timeout and priority:
  - Enter T_MIN, then 30 idle cycles -> IDLE with set_* unchanged.
  - mode+next+up in the same cycle in T_HOUR -> A_HOUR only.
  - Assert reset_in mid-edit -> all outputs return to reset values asynchronously.
